// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-flow controller.
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        DYING     = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [2:0] MAX_LEVEL = 3'd7;
    localparam logic [7:0] SCORE_MAX = 8'h99;

endpackage

// File: rtl/snake_game_ctrl_bcd_inc2.sv
// Two-digit BCD incrementer saturating at 99, plus a BCD greater-than compare.
module bcd_inc2
    import snake_pkg::*;
(
    input  logic [7:0] value,
    input  logic [7:0] other,
    output logic [7:0] incremented,
    output logic       greater
);

    bcd_digit_t tens, units, o_tens, o_units;

    assign tens    = value[7:4];
    assign units   = value[3:0];
    assign o_tens  = other[7:4];
    assign o_units = other[3:0];

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        incremented = value;
        if (value != SCORE_MAX) begin
            if (units == 4'd9) incremented = {tens + 4'd1, 4'd0};
            else               incremented = {tens, units + 4'd1};
        end
    end

    // Tens digit dominates; units only break a tie.
    assign greater = (tens > o_tens) || ((tens == o_tens) && (units > o_units));

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-flow FSM, score-dependent move strobe and BCD score/high-score keeper.
// Define SNAKE_PAUSE_EN to enable the PAUSED state; otherwise pause_btn is ignored.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int FRAMES_BASE      = 8,
    parameter int FRAMES_MIN       = 2,
    parameter int APPLES_PER_LEVEL = 5,
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int DYING_FRAMES     = 60
) (
    input  logic       VGA_clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       frame_tick,
    input  logic       eat,
    input  logic       lethal,
    output logic       play,
    output logic       update,
    output logic       game_over,
    output logic       paused,
    output logic [7:0] score_bcd,
    output logic [7:0] hiscore_bcd,
    output logic [2:0] level,
    output logic [2:0] state
);

`ifdef SNAKE_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int TMR_MAX = (COUNTDOWN_FRAMES > DYING_FRAMES) ? COUNTDOWN_FRAMES : DYING_FRAMES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int APW     = $clog2(APPLES_PER_LEVEL + 1);
    localparam logic [TMR_W-1:0] CD_LAST    = TMR_W'(COUNTDOWN_FRAMES - 1);
    localparam logic [TMR_W-1:0] DY_LAST    = TMR_W'(DYING_FRAMES - 1);
    localparam logic [APW-1:0]   APPLE_LAST = APW'(APPLES_PER_LEVEL - 1);

    game_state_t      cur_state, nxt_state;
    logic             start_q, pause_q, start_edge, pause_edge, clear_game;
    logic [TMR_W-1:0] tmr;
    logic [APW-1:0]   apples;
    logic [3:0]       fcnt, period_q, period_calc;
    logic [7:0]       score_inc;
    logic             score_gt;

    assign start_edge = start_btn & ~start_q;
    assign pause_edge = PAUSE_EN & pause_btn & ~pause_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            cur_state <= IDLE;
            start_q   <= 1'b0;
            pause_q   <= 1'b0;
            tmr       <= '0;
        end else begin
            cur_state <= nxt_state;
            start_q   <= start_btn;
            pause_q   <= pause_btn;
            if (nxt_state != cur_state)
                tmr <= '0;
            else if (frame_tick && (cur_state == COUNTDOWN || cur_state == DYING))
                tmr <= tmr + 1'b1;
        end
    end

    always_comb begin
        nxt_state  = cur_state;
        clear_game = 1'b0;
        unique case (cur_state)
            IDLE, GAME_OVER: if (start_edge) begin
                nxt_state  = COUNTDOWN;
                clear_game = 1'b1;
            end
            COUNTDOWN: if (frame_tick && tmr == CD_LAST) nxt_state = PLAY;
            PLAY: begin
                if (lethal)          nxt_state = DYING;
                else if (pause_edge) nxt_state = PAUSED;
            end
            PAUSED: begin
                if (start_edge)      nxt_state = IDLE;
                else if (pause_edge) nxt_state = PLAY;
            end
            DYING: if (frame_tick && tmr == DY_LAST) nxt_state = GAME_OVER;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        if (FRAMES_BASE - int'(level) < FRAMES_MIN) period_calc = 4'(FRAMES_MIN);
        else                                        period_calc = 4'(FRAMES_BASE - int'(level));
    end

    bcd_inc2 u_bcd_inc2 (
        .value       (score_bcd),
        .other       (hiscore_bcd),
        .incremented (score_inc),
        .greater     (score_gt)
    );

    // The period register is only reloaded on a wrap, so a level change never cuts a count short.
    always_ff @(posedge VGA_clk) begin
        if (reset) begin
            update      <= 1'b0;
            fcnt        <= 4'd0;
            period_q    <= 4'(FRAMES_BASE);
            apples      <= '0;
            level       <= 3'd0;
            score_bcd   <= 8'h00;
            hiscore_bcd <= 8'h00;
        end else begin
            update <= 1'b0;
            if (clear_game) begin
                fcnt      <= 4'd0;
                period_q  <= 4'(FRAMES_BASE);
                apples    <= '0;
                level     <= 3'd0;
                score_bcd <= 8'h00;
            end else if (cur_state == PLAY) begin
                if (frame_tick) begin
                    if (fcnt == period_q - 4'd1) begin
                        fcnt     <= 4'd0;
                        period_q <= period_calc;
                        update   <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 4'd1;
                    end
                end
                if (lethal) begin
                    if (score_gt) hiscore_bcd <= score_bcd;
                end else if (eat) begin
                    score_bcd <= score_inc;
                    if (apples == APPLE_LAST) begin
                        apples <= '0;
                        if (level != MAX_LEVEL) level <= level + 3'd1;
                    end else begin
                        apples <= apples + 1'b1;
                    end
                end
            end
        end
    end

    assign state     = cur_state;
    assign play      = (cur_state == PLAY) || (cur_state == PAUSED);
    assign game_over = (cur_state == DYING) || (cur_state == GAME_OVER);
    assign paused    = PAUSE_EN && (cur_state == PAUSED);

endmodule
